serial_signed_mac: RTL and testbench
====================================

// Module: serial_signed_mac
// PURPOSE
//  Sequential radix-2 shift-add multiplier, next generation of the PE bit-serial multiplier.
//  - Separate A/B widths, per-transaction signed/unsigned mode, internal bit counter (no external
//    metronome/last_count), valid/ready handshake on both sides, optional accumulate.
//  - Sits in the PE datapath between operand buffers and the PE result collector.
// PARAMETERS
//  A_WIDTH     8  multiplicand width (bits), >=2
//  B_WIDTH     8  multiplier width = cycles per product, >=2
//  GUARD_BITS  4  extra MSBs on output for accumulation headroom
//  (derived) P_WIDTH = A_WIDTH+B_WIDTH; OUT_WIDTH = P_WIDTH+GUARD_BITS; CNT_W = clog2(B_WIDTH)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous active-low reset
//  in_valid   in   1          operands valid
//  in_ready   out  1          block can accept operands this cycle
//  a          in   A_WIDTH    multiplicand
//  b          in   B_WIDTH    multiplier, consumed LSB first
//  signed_en  in   1          1: a,b two's complement; 0: unsigned
//  acc_first  in   1          start new accumulation (SERIAL_MAC_ACC_EN only)
//  out_valid  out  1          result valid, held until out_ready
//  out_ready  in   1          downstream accepts result
//  dout       out  OUT_WIDTH  product (or accumulator), sign/zero-extended per signed_en
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, in_ready=0 during reset, out_valid=0, dout=0, counter=0,
//    partial-product reg=0, accumulator=0. Reset mid-RUN/DONE aborts; no result emitted.
//  - FSM: IDLE -> RUN on accept; RUN -> DONE when counter==B_WIDTH-1 at clock edge;
//    DONE -> IDLE on out_ready & ~in_valid; DONE -> RUN on out_ready & in_valid (back-to-back).
//  - in_ready = (IDLE) | (DONE & out_ready). Accept = in_valid & in_ready; a, b, signed_en,
//    acc_first registered on accept; counter cleared; partial product cleared.
//  - RUN, one bit per cycle, bit i = counter: pp = b_reg[i] ? ext(a_reg) : 0; ext = sign- or
//    zero-extend per signed_en. If signed_en and i==B_WIDTH-1, pp is subtracted (two's
//    complement MSB weight); else added. Accumulate at weight 2^i; P_WIDTH+1 internal adder.
//  - Latency: accept at edge k -> out_valid=1 after edge k+B_WIDTH. Throughput: one product
//    per B_WIDTH+1 cycles min (DONE cycle overlaps next accept when out_ready=1).
//  - dout registered, changes only on DONE entry (or reset); stable while out_valid & ~out_ready.
//  - in_valid while busy (RUN, or DONE without out_ready): ignored, in_ready=0, no side effects.
//  - Extremes exact: signed -2^(A-1) * -2^(B-1) = +2^(A+B-2) fits P_WIDTH; no wrap in product.
// CONFIGURATION
//  SERIAL_MAC_ACC_EN defined: on DONE entry acc <= (acc_first_reg ? 0 : acc) + ext(product),
//    OUT_WIDTH wrap-around arithmetic (no saturation); dout = acc; acc cleared only by reset
//    or acc_first. Undefined: acc_first ignored, no accumulator flops, dout = ext(product).
// TESTING
//  1 A=B=8 signed: a=-128,b=-128 -> dout=16384 exactly 8 cycles after accept, out_valid=1.
//  2 unsigned: a=255,b=255,signed_en=0 -> dout=65025; signed_en=1 same bits -> dout=1.
//  3 out_ready held 0 for 5 cycles in DONE -> dout/out_valid stable, in_ready=0; release with
//    in_valid=1 -> next accept same cycle, next result 8 cycles later.
//  4 rst pulsed low mid-RUN (counter=3) -> out_valid=0, dout=0 immediately; next op correct.
//  5 ACC_EN: (3*4,acc_first=1),(-2*5),(7*7) -> dout 12, 2, 51; acc_first=1 again -> restarts.
//  6 random a,b,signed_en x10k vs reference model; A_WIDTH=5,B_WIDTH=11 config also swept.

Source files
------------

// File: rtl/serial_signed_mac.sv
// rtl/serial_signed_mac.sv - radix-2 bit-serial signed/unsigned multiplier, valid/ready both sides
// Optional accumulate enabled by defining SERIAL_MAC_ACC_EN.
module serial_signed_mac #(
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 8,
  parameter int GUARD_BITS = 4,
  localparam int P_WIDTH   = A_WIDTH + B_WIDTH,
  localparam int OUT_WIDTH = P_WIDTH + GUARD_BITS,
  localparam int CNT_W     = $clog2(B_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 signed_en,
  input  logic                 acc_first,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] dout
);

  localparam int X_WIDTH = P_WIDTH + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [X_WIDTH-1:0]   a_sh;
  logic [X_WIDTH-1:0]   prod;
  logic [X_WIDTH-1:0]   pp;
  logic [X_WIDTH-1:0]   prod_next;
  logic [B_WIDTH-1:0]   b_sh;
  logic                 signed_reg;
  logic                 last;
  logic                 accept;
  logic [OUT_WIDTH-1:0] prod_ext;
  logic [OUT_WIDTH-1:0] result_next;

  assign in_ready  = rst & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CNT_W'(B_WIDTH - 1));

  // a_sh already carries weight 2^i; the MSB of a signed multiplier has negative weight
  assign pp        = b_sh[0] ? a_sh : '0;
  assign prod_next = (signed_reg & last) ? prod - pp : prod + pp;
  assign prod_ext  = signed_reg ? OUT_WIDTH'($signed(prod_next[P_WIDTH-1:0]))
                                : OUT_WIDTH'(prod_next[P_WIDTH-1:0]);

`ifdef SERIAL_MAC_ACC_EN
  logic acc_first_reg;
  assign result_next = (acc_first_reg ? '0 : dout) + prod_ext;
`else
  logic unused_acc_first;
  assign unused_acc_first = acc_first;
  assign result_next      = prod_ext;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      a_sh          <= '0;
      b_sh          <= '0;
      prod          <= '0;
      signed_reg    <= 1'b0;
      out_valid     <= 1'b0;
      dout          <= '0;
`ifdef SERIAL_MAC_ACC_EN
      acc_first_reg <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          prod <= prod_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            dout      <= result_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
      // accept only happens in IDLE or DONE, so it overrides the DONE exit above
      if (accept) begin
        state         <= RUN;
        out_valid     <= 1'b0;
        cnt           <= '0;
        prod          <= '0;
        b_sh          <= b;
        signed_reg    <= signed_en;
        a_sh          <= signed_en ? X_WIDTH'($signed(a)) : X_WIDTH'(a);
`ifdef SERIAL_MAC_ACC_EN
        acc_first_reg <= acc_first;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_signed_mac.sv
// tb/tb_serial_signed_mac.sv - randomized bench for serial_signed_mac against an arithmetic reference model
module tb_serial_signed_mac;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int GW = 4;
  localparam int OW = AW + BW + GW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          signed_en = 1'b0;
  logic          acc_first = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] dout;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_signed_mac #(.A_WIDTH(AW), .B_WIDTH(BW), .GUARD_BITS(GW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .signed_en(signed_en), .acc_first(acc_first), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint product(input logic [AW-1:0] x, input logic [BW-1:0] y, input logic s);
    if (s) return longint'($signed(x)) * longint'($signed(y));
    return longint'(x) * longint'(y);
  endfunction

  // Reference model: 0 idle, 1 computing (BW cycles), 2 holding a result
  int            m_state = 0;
  int            m_left = 0;
  logic          m_valid = 1'b0;
  logic [OW-1:0] m_dout = '0;
  logic [AW-1:0] m_a;
  logic [BW-1:0] m_b;
  logic          m_s;
  logic          m_f;

  function automatic logic m_in_ready();
    return rst && (m_state == 0 || (m_state == 2 && out_ready));
  endfunction

  always @(posedge clk or negedge rst) begin
    logic  take;
    longint p;
    if (!rst) begin
      m_state = 0;
      m_left  = 0;
      m_valid = 1'b0;
      m_dout  = '0;
    end else begin
      take = in_valid && m_in_ready();
      if (m_state == 1) begin
        m_left--;
        if (m_left == 0) begin
          p = product(m_a, m_b, m_s);
`ifdef SERIAL_MAC_ACC_EN
          m_dout = OW'((m_f ? 64'sd0 : longint'(m_dout)) + p);
`else
          m_dout = OW'(p);
`endif
          m_valid = 1'b1;
          m_state = 2;
        end
      end else if (m_state == 2 && out_ready) begin
        m_valid = 1'b0;
        m_state = 0;
      end
      if (take) begin
        m_a = a; m_b = b; m_s = signed_en; m_f = acc_first;
        m_state = 1;
        m_left  = BW;
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, m_in_ready());
    check("out_valid", out_valid, m_valid);
    check("dout", dout, m_dout);
  end

  // Called just after a posedge; returns once the operands were taken on an edge.
  task automatic send(input logic [AW-1:0] av, input logic [BW-1:0] bv, input logic s,
                      input logic f, output int waited);
    a = av; b = bv; signed_en = s; acc_first = f; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("send_timeout", waited < 50, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string n, input logic [OW-1:0] exp);
    for (int i = 1; i <= BW; i++) begin
      @(posedge clk); @(negedge clk);
      if (i < BW) check({n, "_early"}, out_valid, 0);
    end
    check({n, "_valid"}, out_valid, 1);
    check({n, "_dout"}, dout, exp);
    check({n, "_model"}, m_dout, exp);
    @(posedge clk); #2;
  endtask

  task automatic op(input string n, input logic [AW-1:0] av, input logic [BW-1:0] bv,
                    input logic s, input logic f, input logic [OW-1:0] exp);
    int w;
    out_ready = 1'b1;
    send(av, bv, s, f, w);
    out_ready = 1'b0;
    wait_result(n, exp);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #2;
    check("reset_dout", dout, 0);
    check("reset_valid", out_valid, 0);
    check("reset_ready", in_ready, 0);
    rst = 1'b1;

    op("min_x_min", 8'h80, 8'h80, 1'b1, 1'b1, 20'd16384);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
      check("hold_dout", dout, 20'd16384);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(8'hFF, 8'hFF, 1'b0, 1'b1, w);
    check("b2b_same_cycle", w, 0);
    out_ready = 1'b0;
    wait_result("uns_255", 20'd65025);
    op("sgn_m1", 8'hFF, 8'hFF, 1'b1, 1'b1, 20'd1);

    out_ready = 1'b1;
    send(8'd5, 8'd7, 1'b0, 1'b1, w);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_dout", dout, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    op("after_abort", 8'hFD, 8'd9, 1'b1, 1'b1, 20'd1048549);

`ifdef SERIAL_MAC_ACC_EN
    op("acc_12", 8'd3, 8'd4, 1'b1, 1'b1, 20'd12);
    op("acc_2", 8'hFE, 8'd5, 1'b1, 1'b0, 20'd2);
    op("acc_51", 8'd7, 8'd7, 1'b1, 1'b0, 20'd51);
    op("acc_restart", 8'd2, 8'd3, 1'b1, 1'b1, 20'd6);
`else
    op("prod_12", 8'd3, 8'd4, 1'b1, 1'b1, 20'd12);
    op("prod_m10", 8'hFE, 8'd5, 1'b1, 1'b0, 20'd1048566);
    op("prod_49", 8'd7, 8'd7, 1'b1, 1'b0, 20'd49);
    op("prod_6", 8'd2, 8'd3, 1'b1, 1'b1, 20'd6);
`endif

    for (int i = 0; i < 20000; i++) begin
      in_valid  = 1'($urandom);
      a         = AW'($urandom);
      b         = BW'($urandom);
      if ($urandom_range(7, 0) == 0) a = 8'h80;
      if ($urandom_range(7, 0) == 0) b = 8'h80;
      if ($urandom_range(9, 0) == 0) a = 8'hFF;
      signed_en = 1'($urandom);
      acc_first = ($urandom_range(3, 0) == 0);
      out_ready = ($urandom_range(3, 0) != 0);
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
